floppy_track_cache: RTL and testbench

FLOPPY_TRACK_CACHE -- requirements
Module: floppy_track_cache

---
 rtl/floppy_track_cache.sv | 242 ++++++++++++++++++++++++
 tb/tb_floppy_track_cache.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floppy_track_cache.sv
// Track-granular cache controller for a floppy image on block storage: loads the
// requested track into a host-side buffer and writes it back when it was modified.
module floppy_track_cache #(
   parameter int MAX_TRACK   = 40,
   parameter int SIDES       = 1,
   parameter int SIDE_OFFSET = 683
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  track,
   input  logic        side,
   input  logic        change,
   input  logic        wr_mark,
   input  logic        flush,
   input  logic        wprot,
   output logic [31:0] sd_lba,
   output logic [5:0]  sd_sz,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   output logic        busy,
   output logic        dirty
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SAVE = 2'd1;
   localparam logic [1:0] S_LOAD = 2'd2;
   localparam logic [1:0] S_INIT = 2'd3;

   localparam logic [5:0] MAX_T  = 6'(MAX_TRACK);
   localparam logic [5:0] INIT_T = 6'd17;

   function automatic logic [31:0] f_lba(input logic [5:0] t, input logic s);
      logic [31:0] tt, a, b, c, d;
      tt = {26'd0, t};
      a  = (tt < 32'd17) ? tt : 32'd17;
      b  = (tt <= 32'd17) ? 32'd0 : (((tt - 32'd17) > 32'd7) ? 32'd7 : (tt - 32'd17));
      c  = (tt <= 32'd24) ? 32'd0 : (((tt - 32'd24) > 32'd6) ? 32'd6 : (tt - 32'd24));
      d  = (tt <= 32'd30) ? 32'd0 : (tt - 32'd30);
      f_lba = 32'd21 * a + 32'd19 * b + 32'd18 * c + 32'd17 * d
            + ((s && (SIDES == 2)) ? 32'(SIDE_OFFSET) : 32'd0);
   endfunction

   function automatic logic [5:0] f_sz(input logic [5:0] t);
      if (t < 6'd17)      f_sz = 6'd20;
      else if (t < 6'd24) f_sz = 6'd18;
      else if (t < 6'd30) f_sz = 6'd17;
      else                f_sz = 6'd16;
   endfunction

   // Synchronizers are deliberately unreset so the toggle history keeps
   // following the live levels while reset is held.
   logic [5:0] r_trk_s1, r_trk_s2, r_trk_s3;
   logic       r_side_s1, r_side_s2, r_side_s3;
   logic       r_chg_s1, r_chg_s2, r_chg_h;
   logic       r_wm_s1, r_wm_s2, r_wm_h;
   logic       r_fl_s1, r_fl_s2, r_fl_h;
   logic       r_wp_s1, r_wp_s2;

   always_ff @(posedge clk) begin
      r_trk_s1  <= track;    r_trk_s2  <= r_trk_s1;  r_trk_s3  <= r_trk_s2;
      r_side_s1 <= side;     r_side_s2 <= r_side_s1; r_side_s3 <= r_side_s2;
      r_chg_s1  <= change;   r_chg_s2  <= r_chg_s1;  r_chg_h   <= r_chg_s2;
      r_wm_s1   <= wr_mark;  r_wm_s2   <= r_wm_s1;   r_wm_h    <= r_wm_s2;
      r_fl_s1   <= flush;    r_fl_s2   <= r_fl_s1;   r_fl_h    <= r_fl_s2;
      r_wp_s1   <= wprot;    r_wp_s2   <= r_wp_s1;
   end

   logic w_chg_rise, w_wm_edge, w_fl_edge;
   assign w_chg_rise = r_chg_s2 & ~r_chg_h;
   assign w_wm_edge  = r_wm_s2 ^ r_wm_h;
   assign w_fl_edge  = r_fl_s2 ^ r_fl_h;

   logic [1:0]  r_state, w_state_next;
   logic [31:0] r_lba, w_lba_next;
   logic [5:0]  r_sz, w_sz_next;
   logic        r_rd, w_rd_next, r_wr, w_wr_next, r_busy, w_busy_next;
   logic        r_dirty, w_dirty_next;
   logic [5:0]  r_cache_t, w_cache_t_next, r_load_t, w_load_t_next;
   logic        r_cache_s, w_cache_s_next, r_load_s, w_load_s_next;
   logic        r_cache_v, w_cache_v_next;
   logic        r_init_pend, w_init_pend_next, r_chg_pend, w_chg_pend_next;
   logic        r_ack_d;

   logic [5:0] w_t;
   logic       w_s, w_differs, w_can_save, w_ack_fall;

   always_comb begin
      if (r_trk_s3 == 6'd0)      w_t = 6'd0;
      else if (r_trk_s3 > MAX_T) w_t = MAX_T - 6'd1;
      else                       w_t = r_trk_s3 - 6'd1;
   end

   assign w_s        = (SIDES == 2) ? r_side_s3 : 1'b0;
   assign w_differs  = ~r_cache_v | (w_t != r_cache_t) | (w_s != r_cache_s);
   assign w_can_save = r_dirty & r_cache_v & ~r_wp_s2;
   assign w_ack_fall = r_ack_d & ~sd_ack;

   always_comb begin
      w_state_next     = r_state;
      w_lba_next       = r_lba;
      w_sz_next        = r_sz;
      w_rd_next        = r_rd;
      w_wr_next        = r_wr;
      w_busy_next      = r_busy;
      w_dirty_next     = r_dirty;
      w_cache_t_next   = r_cache_t;
      w_cache_s_next   = r_cache_s;
      w_cache_v_next   = r_cache_v;
      w_load_t_next    = r_load_t;
      w_load_s_next    = r_load_s;
      w_init_pend_next = r_init_pend;
      w_chg_pend_next  = r_chg_pend;

      if (sd_ack) begin
         w_rd_next = 1'b0;
         w_wr_next = 1'b0;
      end
      if (w_wm_edge && (r_state != S_LOAD) && (r_state != S_INIT))
         w_dirty_next = 1'b1;
      if (w_chg_rise && r_busy)
         w_chg_pend_next = 1'b1;

      case (r_state)
         S_IDLE: begin
            if (w_chg_rise) begin
               w_dirty_next     = 1'b0;
               w_init_pend_next = 1'b1;
               w_cache_v_next   = 1'b0;
            end else if ((w_fl_edge || w_differs) && w_can_save && (w_fl_edge || !r_init_pend)) begin
               w_state_next = S_SAVE;
               w_lba_next   = f_lba(r_cache_t, r_cache_s);
               w_sz_next    = f_sz(r_cache_t);
               w_wr_next    = 1'b1;
               w_busy_next  = 1'b1;
            end else if (r_init_pend) begin
               w_state_next     = S_INIT;
               w_lba_next       = f_lba(INIT_T, 1'b0);
               w_sz_next        = f_sz(INIT_T);
               w_rd_next        = 1'b1;
               w_busy_next      = 1'b1;
               w_load_t_next    = INIT_T;
               w_load_s_next    = 1'b0;
               w_init_pend_next = 1'b0;
            end else if (w_differs) begin
               w_state_next  = S_LOAD;
               w_lba_next    = f_lba(w_t, w_s);
               w_sz_next     = f_sz(w_t);
               w_rd_next     = 1'b1;
               w_busy_next   = 1'b1;
               w_load_t_next = w_t;
               w_load_s_next = w_s;
            end
         end
         S_SAVE: begin
            if (w_ack_fall) begin
               w_dirty_next = 1'b0;
               if (r_chg_pend || w_chg_rise) begin
                  w_chg_pend_next  = 1'b0;
                  w_init_pend_next = 1'b1;
                  w_cache_v_next   = 1'b0;
                  w_busy_next      = 1'b0;
                  w_state_next     = S_IDLE;
               end else if (w_differs) begin
                  // Chain straight into the load; busy never drops in between.
                  w_state_next  = S_LOAD;
                  w_lba_next    = f_lba(w_t, w_s);
                  w_sz_next     = f_sz(w_t);
                  w_rd_next     = 1'b1;
                  w_load_t_next = w_t;
                  w_load_s_next = w_s;
               end else begin
                  w_busy_next  = 1'b0;
                  w_state_next = S_IDLE;
               end
            end
         end
         default: begin
            if (w_ack_fall) begin
               w_cache_t_next = r_load_t;
               w_cache_s_next = r_load_s;
               w_cache_v_next = 1'b1;
               w_dirty_next   = 1'b0;
               w_busy_next    = 1'b0;
               w_state_next   = S_IDLE;
               if (r_chg_pend || w_chg_rise) begin
                  w_cache_v_next   = 1'b0;
                  w_init_pend_next = 1'b1;
                  w_chg_pend_next  = 1'b0;
               end
            end
         end
      endcase

      if (r_wp_s2)
         w_dirty_next = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_lba       <= 32'd0;
         r_sz        <= 6'd0;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_busy      <= 1'b0;
         r_dirty     <= 1'b0;
         r_cache_t   <= 6'd0;
         r_cache_s   <= 1'b0;
         r_cache_v   <= 1'b0;
         r_load_t    <= 6'd0;
         r_load_s    <= 1'b0;
         r_init_pend <= 1'b1;
         r_chg_pend  <= 1'b0;
         r_ack_d     <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_lba       <= w_lba_next;
         r_sz        <= w_sz_next;
         r_rd        <= w_rd_next;
         r_wr        <= w_wr_next;
         r_busy      <= w_busy_next;
         r_dirty     <= w_dirty_next;
         r_cache_t   <= w_cache_t_next;
         r_cache_s   <= w_cache_s_next;
         r_cache_v   <= w_cache_v_next;
         r_load_t    <= w_load_t_next;
         r_load_s    <= w_load_s_next;
         r_init_pend <= w_init_pend_next;
         r_chg_pend  <= w_chg_pend_next;
         r_ack_d     <= sd_ack;
      end
   end

   assign sd_lba = r_lba;
   assign sd_sz  = r_sz;
   assign sd_rd  = r_rd;
   assign sd_wr  = r_wr;
   assign busy   = r_busy;
   assign dirty  = r_dirty;

endmodule

// File: tb/tb_floppy_track_cache.sv
// Directed bench for floppy_track_cache with a hand-driven host acknowledge.
module tb_floppy_track_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  track;
   logic        side, change, wr_mark, flush, wprot, sd_ack;
   logic [31:0] sd_lba;
   logic [5:0]  sd_sz;
   logic        sd_rd, sd_wr, busy, dirty;

   int checks = 0;
   int errors = 0;

   logic        f_rd, f_wr, ok, saw;
   logic [31:0] f_lba;
   logic [5:0]  f_sz;

   always #5 clk = ~clk;

   floppy_track_cache #(.MAX_TRACK(40), .SIDES(2), .SIDE_OFFSET(683)) dut (
      .clk(clk), .reset(reset), .track(track), .side(side), .change(change),
      .wr_mark(wr_mark), .flush(flush), .wprot(wprot), .sd_lba(sd_lba),
      .sd_sz(sd_sz), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .busy(busy), .dirty(dirty)
   );

   task automatic wait_req(output logic o_rd, output logic o_wr, output logic [31:0] o_lba,
                           output logic [5:0] o_sz, output logic o_ok);
      o_ok = 1'b0; o_rd = 1'b0; o_wr = 1'b0; o_lba = 32'd0; o_sz = 6'd0;
      for (int i = 0; i < 40 && !o_ok; i++) begin
         @(negedge clk);
         if (sd_rd || sd_wr) begin
            o_ok = 1'b1; o_rd = sd_rd; o_wr = sd_wr; o_lba = sd_lba; o_sz = sd_sz;
         end
      end
      $display("request: rd=%0b wr=%0b lba=%0d sz=%0d seen=%0b", o_rd, o_wr, o_lba, o_sz, o_ok);
   endtask

   task automatic ack_xfer();
      sd_ack = 1'b1;
      repeat (2) @(negedge clk);
      sd_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic quiet(input int n, output logic o_saw);
      o_saw = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (sd_rd || sd_wr) o_saw = 1'b1;
      end
   endtask

   task automatic toggle_wr_mark();
      wr_mark = ~wr_mark;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (5) @(negedge clk);
      checks++;
      if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b0 || dirty !== 1'b0 || sd_lba !== 32'd0 || sd_sz !== 6'd0) begin
         errors++;
         $display("FAIL reset_state: rd=%0b wr=%0b busy=%0b dirty=%0b lba=%0d sz=%0d, expected all zero",
                  sd_rd, sd_wr, busy, dirty, sd_lba, sd_sz);
      end
      reset = 1'b0;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_rd === 1'b1 && f_wr === 1'b0 && f_lba === 32'd357 && f_sz === 6'd18 && busy === 1'b1)) begin
         errors++;
         $display("FAIL init_req: seen=%0b rd=%0b wr=%0b lba=%0d sz=%0d busy=%0b, expected rd lba=357 sz=18 busy=1",
                  ok, f_rd, f_wr, f_lba, f_sz, busy);
      end
      sd_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (sd_rd !== 1'b0 || busy !== 1'b1 || sd_lba !== 32'd357) begin
         errors++;
         $display("FAIL rd_drop: rd=%0b busy=%0b lba=%0d, expected rd=0 busy=1 lba=357", sd_rd, busy, sd_lba);
      end
      @(negedge clk);
      sd_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL init_done: busy=%0b, expected 0", busy);
      end
      quiet(20, saw);
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL init_quiet: saw request=%0b, expected none", saw);
      end
   endtask

   task automatic test_track_map();
      logic [5:0]  trk_tab[8] = '{6'd1, 6'd35, 6'd50, 6'd0, 6'd25, 6'd30, 6'd17, 6'd18};
      logic [31:0] lba_tab[8] = '{32'd0, 32'd666, 32'd751, 32'd0, 32'd490, 32'd580, 32'd336, 32'd357};
      logic [5:0]  sz_tab[8]  = '{6'd20, 6'd16, 6'd16, 6'd20, 6'd17, 6'd17, 6'd20, 6'd18};
      for (int i = 0; i < 8; i++) begin
         track = trk_tab[i];
         wait_req(f_rd, f_wr, f_lba, f_sz, ok);
         checks++;
         if (!(ok && f_rd === 1'b1 && f_wr === 1'b0 && f_lba === lba_tab[i] && f_sz === sz_tab[i])) begin
            errors++;
            $display("FAIL map_track%0d: seen=%0b rd=%0b wr=%0b lba=%0d sz=%0d, expected rd lba=%0d sz=%0d",
                     trk_tab[i], ok, f_rd, f_wr, f_lba, f_sz, lba_tab[i], sz_tab[i]);
         end
         ack_xfer();
      end
      track = 6'd50;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      ack_xfer();
      track = 6'd40;
      quiet(20, saw);
      checks++;
      if (saw !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL clamp_same: saw request=%0b busy=%0b, expected no request after 50->40", saw, busy);
      end
   endtask

   task automatic test_save_load();
      track = 6'd18;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      ack_xfer();
      toggle_wr_mark();
      checks++;
      if (dirty !== 1'b1) begin
         errors++;
         $display("FAIL dirty_set: dirty=%0b, expected 1", dirty);
      end
      track = 6'd19;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_wr === 1'b1 && f_rd === 1'b0 && f_lba === 32'd357 && f_sz === 6'd18)) begin
         errors++;
         $display("FAIL save_req: seen=%0b rd=%0b wr=%0b lba=%0d sz=%0d, expected wr lba=357 sz=18",
                  ok, f_rd, f_wr, f_lba, f_sz);
      end
      sd_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (sd_wr !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL wr_drop: wr=%0b busy=%0b, expected wr=0 busy=1", sd_wr, busy);
      end
      @(negedge clk);
      sd_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (!(busy === 1'b1 && sd_rd === 1'b1 && sd_wr === 1'b0 && sd_lba === 32'd376 && sd_sz === 6'd18 && dirty === 1'b0)) begin
         errors++;
         $display("FAIL chain_load: busy=%0b rd=%0b wr=%0b lba=%0d sz=%0d dirty=%0b, expected busy=1 rd lba=376 sz=18 dirty=0",
                  busy, sd_rd, sd_wr, sd_lba, sd_sz, dirty);
      end
      ack_xfer();
      quiet(10, saw);
      checks++;
      if (saw !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL chain_done: saw request=%0b busy=%0b, expected idle", saw, busy);
      end
   endtask

   task automatic test_flush();
      flush = ~flush;
      quiet(15, saw);
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL flush_clean: saw request=%0b, expected none when clean", saw);
      end
      toggle_wr_mark();
      flush = ~flush;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_wr === 1'b1 && f_rd === 1'b0 && f_lba === 32'd376 && f_sz === 6'd18)) begin
         errors++;
         $display("FAIL flush_save: seen=%0b rd=%0b wr=%0b lba=%0d sz=%0d, expected wr lba=376 sz=18",
                  ok, f_rd, f_wr, f_lba, f_sz);
      end
      ack_xfer();
      quiet(10, saw);
      checks++;
      if (saw !== 1'b0 || busy !== 1'b0 || dirty !== 1'b0) begin
         errors++;
         $display("FAIL flush_done: saw=%0b busy=%0b dirty=%0b, expected all 0", saw, busy, dirty);
      end
   endtask

   task automatic test_side();
      track = 6'd1;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      ack_xfer();
      side = 1'b1;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_rd === 1'b1 && f_wr === 1'b0 && f_lba === 32'd683 && f_sz === 6'd20)) begin
         errors++;
         $display("FAIL side1_load: seen=%0b rd=%0b wr=%0b lba=%0d sz=%0d, expected rd lba=683 sz=20",
                  ok, f_rd, f_wr, f_lba, f_sz);
      end
      ack_xfer();
      side = 1'b0;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_rd === 1'b1 && f_lba === 32'd0 && f_sz === 6'd20)) begin
         errors++;
         $display("FAIL side0_load: seen=%0b rd=%0b lba=%0d sz=%0d, expected rd lba=0 sz=20", ok, f_rd, f_lba, f_sz);
      end
      ack_xfer();
   endtask

   task automatic test_wprot();
      wprot = 1'b1;
      repeat (4) @(negedge clk);
      wr_mark = ~wr_mark;
      flush   = ~flush;
      quiet(20, saw);
      checks++;
      if (saw !== 1'b0 || dirty !== 1'b0) begin
         errors++;
         $display("FAIL wprot: saw request=%0b dirty=%0b, expected no request and dirty=0", saw, dirty);
      end
      wprot = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_change();
      toggle_wr_mark();
      track = 6'd2;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_wr === 1'b1 && f_lba === 32'd0 && f_sz === 6'd20)) begin
         errors++;
         $display("FAIL chg_save: seen=%0b wr=%0b lba=%0d sz=%0d, expected wr lba=0 sz=20", ok, f_wr, f_lba, f_sz);
      end
      ack_xfer();
      checks++;
      if (!(sd_rd === 1'b1 && sd_lba === 32'd21 && busy === 1'b1)) begin
         errors++;
         $display("FAIL chg_load: rd=%0b lba=%0d busy=%0b, expected rd lba=21 busy=1", sd_rd, sd_lba, busy);
      end
      change  = 1'b1;
      wr_mark = ~wr_mark;
      repeat (6) @(negedge clk);
      ack_xfer();
      checks++;
      if (dirty !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL chg_after_load: dirty=%0b busy=%0b, expected 0 0", dirty, busy);
      end
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_rd === 1'b1 && f_wr === 1'b0 && f_lba === 32'd357 && f_sz === 6'd18)) begin
         errors++;
         $display("FAIL chg_reinit: seen=%0b rd=%0b wr=%0b lba=%0d sz=%0d, expected rd lba=357 sz=18",
                  ok, f_rd, f_wr, f_lba, f_sz);
      end
      ack_xfer();
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_rd === 1'b1 && f_lba === 32'd21)) begin
         errors++;
         $display("FAIL chg_reload: seen=%0b rd=%0b lba=%0d, expected rd lba=21", ok, f_rd, f_lba);
      end
      ack_xfer();
      change = 1'b0;
      repeat (5) @(negedge clk);
      toggle_wr_mark();
      change = 1'b1;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_rd === 1'b1 && f_wr === 1'b0 && f_lba === 32'd357 && dirty === 1'b0)) begin
         errors++;
         $display("FAIL chg_idle: seen=%0b rd=%0b wr=%0b lba=%0d dirty=%0b, expected rd lba=357 dirty=0",
                  ok, f_rd, f_wr, f_lba, dirty);
      end
      ack_xfer();
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      ack_xfer();
   endtask

   task automatic test_reset_midxfer();
      track = 6'd3;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_rd === 1'b1 && f_lba === 32'd42)) begin
         errors++;
         $display("FAIL mid_req: seen=%0b rd=%0b lba=%0d, expected rd lba=42", ok, f_rd, f_lba);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (sd_rd !== 1'b0 || busy !== 1'b0 || sd_lba !== 32'd0 || sd_sz !== 6'd0) begin
         errors++;
         $display("FAIL async_reset: rd=%0b busy=%0b lba=%0d sz=%0d, expected all zero", sd_rd, busy, sd_lba, sd_sz);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      checks++;
      if (!(ok && f_rd === 1'b1 && f_lba === 32'd357 && f_sz === 6'd18)) begin
         errors++;
         $display("FAIL reset_reinit: seen=%0b rd=%0b lba=%0d sz=%0d, expected rd lba=357 sz=18", ok, f_rd, f_lba, f_sz);
      end
      ack_xfer();
      wait_req(f_rd, f_wr, f_lba, f_sz, ok);
      ack_xfer();
   endtask

   initial begin
      reset = 1'b1; track = 6'd18; side = 1'b0; change = 1'b0; wr_mark = 1'b0;
      flush = 1'b0; wprot = 1'b0; sd_ack = 1'b0;
      test_reset();
      test_track_map();
      test_save_load();
      test_flush();
      test_side();
      test_wprot();
      test_change();
      test_reset_midxfer();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
